// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU engine: alu1bit opcode encoding and sequencer states.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_NOR = 2'b00,
        ALU_XOR = 2'b01,
        ALU_ADD = 2'b10,
        ALU_SUB = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } alu_state_e;

    // ADD and SUB are the only ops that propagate a carry/borrow.
    function automatic logic is_arith(alu_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_serial_engine_if.sv
// Request/response bundle between a controller and the bit-serial ALU engine.
interface alu_serial_engine_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;

    modport master (
        output start, op, a, b, cin,
        input  busy, done, result, cout
    );

    modport slave (
        input  start, op, a, b, cin,
        output busy, done, result, cout
    );
endinterface

// File: rtl/alu1bit.sv
// One-bit ALU datapath cell: NOR / XOR / full-add / full-subtract with carry or borrow out.
module alu1bit
    import alu_pkg::*;
(
    input  logic    a,
    input  logic    b,
    input  logic    cin,
    input  alu_op_e op,
    output logic    s,
    output logic    cout
);

    always_comb begin
        s    = 1'b0;
        cout = 1'b0;
        case (op)
            ALU_NOR: s = ~(a | b);
            ALU_XOR: s = a ^ b;
            ALU_ADD: begin
                s    = a ^ b ^ cin;
                cout = (a & b) | (a & cin) | (b & cin);
            end
            ALU_SUB: begin
                s    = a ^ b ^ cin;
                cout = (~a & b) | (~a & cin) | (b & cin);
            end
            default: begin
                s    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial_engine.sv
// Bit-serial WIDTH-bit ALU: latches operands on start, feeds alu1bit one bit per clock LSB first,
// chains carry/borrow through a flop and pulses done with the assembled result.
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | shifting one operand bit per clock through alu1bit
// DONE    | done pulse cycle; start here is accepted back-to-back
module alu_serial_engine
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    alu_serial_engine_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    alu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    alu_op_e          op_q, op_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic bit_s;
    logic bit_c;

    alu1bit u_alu1bit (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .op   (op_q),
        .s    (bit_s),
        .cout (bit_c)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        result_d = result_q;
        op_d     = op_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (bus.start) begin
                    state_d  = ST_RUN;
                    a_sh_d   = bus.a;
                    b_sh_d   = bus.b;
                    op_d     = alu_op_e'(bus.op);
                    carry_d  = is_arith(alu_op_e'(bus.op)) ? bus.cin : 1'b0;
                    cnt_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            ST_RUN: begin
                result_d = {bit_s, result_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = bit_c;
                if (cnt_q == CNT_LAST) begin
                    // Counter parks at the last index; it is reloaded on the next accept.
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cout_d  = is_arith(op_q) ? bit_c : 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            result_q <= '0;
            op_q     <= ALU_NOR;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            result_q <= result_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;

endmodule

// File: tb/tb_alu_serial_engine.sv
// Directed bench for alu_serial_engine at WIDTH=8: latency, op results, back-to-back, ignored start, reset abort.
module tb_alu_serial_engine;
    import alu_pkg::*;

    localparam int W = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    alu_serial_engine_if #(.WIDTH(W)) bus ();

    alu_serial_engine #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge just after the accepting edge with start low.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.cout} !== 3'b000 || bus.result !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b result=%h cout=%b, want all 0",
                     bus.busy, bus.done, bus.result, bus.cout);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_ops();
        logic [1:0]   v_op  [6] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01};
        logic [W-1:0] v_a   [6] = '{8'h5A, 8'hFF, 8'h10, 8'h00, 8'h0F, 8'h0F};
        logic [W-1:0] v_b   [6] = '{8'h3C, 8'h01, 8'h01, 8'h01, 8'h33, 8'h33};
        logic         v_cin [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] v_res [6] = '{8'h96, 8'h00, 8'h0F, 8'hFE, 8'hC0, 8'h3C};
        logic         v_co  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        int busy_cycles;
        for (int v = 0; v < 6; v++) begin
            issue(v_op[v], v_a[v], v_b[v], v_cin[v]);
            busy_cycles = 0;
            for (int k = 0; k < W; k++) begin
                if (bus.busy === 1'b1 && bus.done === 1'b0) busy_cycles++;
                step();
            end
            n_checks++;
            if (busy_cycles != W) begin
                n_fail++;
                $display("FAIL op%0d_busy_window: busy-only cycles=%0d, want %0d", v, busy_cycles, W);
            end
            n_checks++;
            if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL op%0d_done_latency: done=%b busy=%b at cycle %0d, want 1 0",
                         v, bus.done, bus.busy, W);
            end
            n_checks++;
            if (bus.result !== v_res[v] || bus.cout !== v_co[v]) begin
                n_fail++;
                $display("FAIL op%0d_result: result=%h cout=%b, want %h %b",
                         v, bus.result, bus.cout, v_res[v], v_co[v]);
            end
            step();
            n_checks++;
            if (bus.done !== 1'b0 || bus.result !== v_res[v]) begin
                n_fail++;
                $display("FAIL op%0d_pulse_hold: done=%b result=%h, want 0 %h",
                         v, bus.done, bus.result, v_res[v]);
            end
        end
    endtask

    task automatic test_back_to_back();
        issue(2'b01, 8'h0F, 8'h33, 1'b0);
        for (int k = 0; k < W; k++) step();
        n_checks++;
        if (bus.done !== 1'b1 || bus.result !== 8'h3C) begin
            n_fail++;
            $display("FAIL b2b_first_done: done=%b result=%h, want 1 3c", bus.done, bus.result);
        end
        issue(2'b10, 8'h01, 8'h01, 1'b0);
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.result !== 8'h00 || bus.cout !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: done=%b busy=%b result=%h cout=%b, want 0 1 00 0",
                     bus.done, bus.busy, bus.result, bus.cout);
        end
        for (int k = 0; k < W; k++) step();
        n_checks++;
        if (bus.done !== 1'b1 || bus.result !== 8'h02 || bus.cout !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: done=%b result=%h cout=%b, want 1 02 0",
                     bus.done, bus.result, bus.cout);
        end
        step();
    endtask

    task automatic test_ignore_start();
        int done_cnt;
        int done_at;
        done_cnt = 0;
        done_at  = -1;
        issue(2'b10, 8'h5A, 8'h3C, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            if (k == 3) begin
                bus.start = 1'b1;
                bus.op    = 2'b11;
                bus.a     = 8'hFF;
                bus.b     = 8'hFF;
                bus.cin   = 1'b1;
            end else if (k == 4) begin
                bus.start = 1'b0;
                bus.a     = 8'h00;
                bus.b     = 8'hA5;
            end
            step();
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_at = k;
                n_checks++;
                if (bus.result !== 8'h96 || bus.cout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ignore_result: result=%h cout=%b, want 96 0", bus.result, bus.cout);
                end
            end
        end
        n_checks++;
        if (done_cnt != 1 || done_at != W) begin
            n_fail++;
            $display("FAIL ignore_single_done: count=%0d at cycle %0d, want 1 at %0d",
                     done_cnt, done_at, W);
        end
    endtask

    task automatic test_reset_abort();
        int done_seen;
        done_seen = 0;
        issue(2'b10, 8'h5A, 8'h3C, 1'b0);
        step();
        step();
        step();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.cout} !== 3'b000 || bus.result !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_immediate: busy=%b done=%b result=%h cout=%b, want all 0",
                     bus.busy, bus.done, bus.result, bus.cout);
        end
        @(negedge clk);
        step();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
        end
        n_checks++;
        if (done_seen != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: busy/done cycles=%0d, want 0", done_seen);
        end
        issue(2'b10, 8'h80, 8'h80, 1'b0);
        for (int k = 0; k < W; k++) step();
        n_checks++;
        if (bus.done !== 1'b1 || bus.result !== 8'h00 || bus.cout !== 1'b1) begin
            n_fail++;
            $display("FAIL post_abort_add: done=%b result=%h cout=%b, want 1 00 1",
                     bus.done, bus.result, bus.cout);
        end
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_ops();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
